// File: rtl/csr_file.sv
// Machine-mode CSR storage for the alioth core: trap CSRs, 64-bit cycle/instret counters
// and mhartid, served through independent ex and clint read/write ports.
module csr_file #(
  parameter logic [31:0] HART_ID     = 32'h0,
  parameter logic [31:0] MTVEC_RESET = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_we_i,
  input  logic [31:0] ex_waddr_i,
  input  logic [31:0] ex_data_i,
  input  logic [31:0] ex_raddr_i,
  output logic [31:0] ex_data_o,
  input  logic        clint_we_i,
  input  logic [31:0] clint_waddr_i,
  input  logic [31:0] clint_data_i,
  input  logic [31:0] clint_raddr_i,
  output logic [31:0] clint_data_o,
  input  logic        inst_retire_i,
  output logic [31:0] csr_mtvec_o,
  output logic [31:0] csr_mepc_o,
  output logic [31:0] csr_mstatus_o,
  output logic        global_int_en_o
);

  localparam logic [11:0] AddrMstatus   = 12'h300;
  localparam logic [11:0] AddrMie       = 12'h304;
  localparam logic [11:0] AddrMtvec     = 12'h305;
  localparam logic [11:0] AddrMscratch  = 12'h340;
  localparam logic [11:0] AddrMepc      = 12'h341;
  localparam logic [11:0] AddrMcause    = 12'h342;
  localparam logic [11:0] AddrMcycle    = 12'hB00;
  localparam logic [11:0] AddrMinstret  = 12'hB02;
  localparam logic [11:0] AddrMcycleh   = 12'hB80;
  localparam logic [11:0] AddrMinstreth = 12'hB82;
  localparam logic [11:0] AddrMhartid   = 12'hF14;

  localparam logic [31:0] MstatusReset = 32'h0000_1800;

  logic [31:0] mstatus_q, mstatus_d;
  logic [31:0] mie_q, mie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;

  logic        ex_win;
  logic        pwe [2];
  logic [11:0] pwa [2];
  logic [31:0] pwd [2];
  logic [11:0] pra [2];
  logic [31:0] prd [2];

  function automatic logic writable(input logic [11:0] a);
    case (a)
      AddrMstatus, AddrMie, AddrMtvec, AddrMscratch, AddrMepc, AddrMcause,
      AddrMcycle, AddrMinstret, AddrMcycleh, AddrMinstreth: writable = 1'b1;
      default: writable = 1'b0;
    endcase
  endfunction

  // Value as it will be stored (and therefore read back) for a write of d to a.
  function automatic logic [31:0] wmask(input logic [11:0] a, input logic [31:0] d);
    case (a)
      AddrMstatus:          wmask = {19'b0, 2'b11, 3'b0, d[7], 3'b0, d[3], 3'b0};
      AddrMie:              wmask = d & 32'h0000_0888;
      AddrMtvec, AddrMepc:  wmask = {d[31:2], 2'b00};
      default:              wmask = d;
    endcase
  endfunction

  // Same-address collision: clint wins, ex write is dropped entirely.
  assign ex_win = ex_we_i && !(clint_we_i && (ex_waddr_i[11:0] == clint_waddr_i[11:0]));

  // Port 0 = ex, port 1 = clint; clint applied last so it overrides.
  assign pwe[0] = ex_win;
  assign pwa[0] = ex_waddr_i[11:0];
  assign pwd[0] = ex_data_i;
  assign pwe[1] = clint_we_i;
  assign pwa[1] = clint_waddr_i[11:0];
  assign pwd[1] = clint_data_i;
  assign pra[0] = ex_raddr_i[11:0];
  assign pra[1] = clint_raddr_i[11:0];

  always_comb begin
    logic        cyc_lo_wr, cyc_hi_wr, ins_lo_wr, ins_hi_wr;
    logic [31:0] cyc_lo, cyc_hi, ins_lo, ins_hi;
    mstatus_d  = mstatus_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    cyc_lo_wr  = 1'b0;
    cyc_hi_wr  = 1'b0;
    ins_lo_wr  = 1'b0;
    ins_hi_wr  = 1'b0;
    cyc_lo     = mcycle_q[31:0];
    cyc_hi     = mcycle_q[63:32];
    ins_lo     = minstret_q[31:0];
    ins_hi     = minstret_q[63:32];
    for (int p = 0; p < 2; p++) begin
      if (pwe[p]) begin
        case (pwa[p])
          AddrMstatus:   mstatus_d  = wmask(pwa[p], pwd[p]);
          AddrMie:       mie_d      = wmask(pwa[p], pwd[p]);
          AddrMtvec:     mtvec_d    = wmask(pwa[p], pwd[p]);
          AddrMscratch:  mscratch_d = pwd[p];
          AddrMepc:      mepc_d     = wmask(pwa[p], pwd[p]);
          AddrMcause:    mcause_d   = pwd[p];
          AddrMcycle:    begin cyc_lo_wr = 1'b1; cyc_lo = pwd[p]; end
          AddrMcycleh:   begin cyc_hi_wr = 1'b1; cyc_hi = pwd[p]; end
          AddrMinstret:  begin ins_lo_wr = 1'b1; ins_lo = pwd[p]; end
          AddrMinstreth: begin ins_hi_wr = 1'b1; ins_hi = pwd[p]; end
          default: ;
        endcase
      end
    end
    // Any write to either half replaces that half and suppresses the increment.
    if (cyc_lo_wr || cyc_hi_wr) begin
      mcycle_d = {cyc_hi, cyc_lo};
    end else begin
      mcycle_d = mcycle_q + 64'd1;
    end
    if (ins_lo_wr || ins_hi_wr) begin
      minstret_d = {ins_hi, ins_lo};
    end else begin
      minstret_d = minstret_q + {63'd0, inst_retire_i};
    end
  end

  always_comb begin
    for (int r = 0; r < 2; r++) begin
      case (pra[r])
        AddrMstatus:   prd[r] = mstatus_q;
        AddrMie:       prd[r] = mie_q;
        AddrMtvec:     prd[r] = mtvec_q;
        AddrMscratch:  prd[r] = mscratch_q;
        AddrMepc:      prd[r] = mepc_q;
        AddrMcause:    prd[r] = mcause_q;
        AddrMcycle:    prd[r] = mcycle_q[31:0];
        AddrMcycleh:   prd[r] = mcycle_q[63:32];
        AddrMinstret:  prd[r] = minstret_q[31:0];
        AddrMinstreth: prd[r] = minstret_q[63:32];
        AddrMhartid:   prd[r] = HART_ID;
        default:       prd[r] = 32'h0;
      endcase
      for (int p = 0; p < 2; p++) begin
        if (pwe[p] && (pwa[p] == pra[r]) && writable(pwa[p])) begin
          prd[r] = wmask(pwa[p], pwd[p]);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mstatus_q  <= MstatusReset;
      mie_q      <= 32'h0;
      mtvec_q    <= MTVEC_RESET & ~32'h3;
      mscratch_q <= 32'h0;
      mepc_q     <= 32'h0;
      mcause_q   <= 32'h0;
      mcycle_q   <= 64'h0;
      minstret_q <= 64'h0;
    end else begin
      mstatus_q  <= mstatus_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

  assign ex_data_o       = prd[0];
  assign clint_data_o    = prd[1];
  assign csr_mtvec_o     = mtvec_q;
  assign csr_mepc_o      = mepc_q;
  assign csr_mstatus_o   = mstatus_q;
  assign global_int_en_o = mstatus_q[3];

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: expectations queued as stimulus is applied, then
// drained and compared against DUT outputs mid-cycle.
module tb_csr_file;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_we_i = 1'b0;
  logic [31:0] ex_waddr_i = '0, ex_data_i = '0, ex_raddr_i = '0;
  logic [31:0] ex_data_o;
  logic        clint_we_i = 1'b0;
  logic [31:0] clint_waddr_i = '0, clint_data_i = '0, clint_raddr_i = '0;
  logic [31:0] clint_data_o;
  logic        inst_retire_i = 1'b0;
  logic [31:0] csr_mtvec_o, csr_mepc_o, csr_mstatus_o;
  logic        global_int_en_o;

  csr_file #(.HART_ID(32'h0), .MTVEC_RESET(32'h0)) dut (
    .clk(clk), .rst(rst),
    .ex_we_i(ex_we_i), .ex_waddr_i(ex_waddr_i), .ex_data_i(ex_data_i),
    .ex_raddr_i(ex_raddr_i), .ex_data_o(ex_data_o),
    .clint_we_i(clint_we_i), .clint_waddr_i(clint_waddr_i), .clint_data_i(clint_data_i),
    .clint_raddr_i(clint_raddr_i), .clint_data_o(clint_data_o),
    .inst_retire_i(inst_retire_i),
    .csr_mtvec_o(csr_mtvec_o), .csr_mepc_o(csr_mepc_o), .csr_mstatus_o(csr_mstatus_o),
    .global_int_en_o(global_int_en_o)
  );

  always #5 clk = ~clk;

  localparam int SEx = 0, SCl = 1, SMtvec = 2, SMepc = 3, SMstatus = 4, SGie = 5;

  typedef struct {
    string       tag;
    int          src;
    logic [31:0] exp;
  } sb_entry_t;

  sb_entry_t sb[$];
  int n_cmp = 0;
  int n_fail = 0;

  function automatic logic [31:0] pick(input int src);
    case (src)
      SEx:      pick = ex_data_o;
      SCl:      pick = clint_data_o;
      SMtvec:   pick = csr_mtvec_o;
      SMepc:    pick = csr_mepc_o;
      SMstatus: pick = csr_mstatus_o;
      default:  pick = {31'b0, global_int_en_o};
    endcase
  endfunction

  task automatic expect_val(input int src, input string tag, input logic [31:0] v);
    sb_entry_t e;
    e.tag = tag;
    e.src = src;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    sb_entry_t e;
    logic [31:0] obs;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = pick(e.src);
      n_cmp++;
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s: got %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic ex_wr(input logic we, input logic [31:0] a, input logic [31:0] d);
    ex_we_i = we; ex_waddr_i = a; ex_data_i = d;
  endtask

  task automatic cl_wr(input logic we, input logic [31:0] a, input logic [31:0] d);
    clint_we_i = we; clint_waddr_i = a; clint_data_i = d;
  endtask

  task automatic rd(input logic [31:0] ea, input logic [31:0] ca);
    ex_raddr_i = ea; clint_raddr_i = ca;
  endtask

  initial begin
    // Reset held
    repeat (3) @(negedge clk);
    rd(32'hB00, 32'h300);
    expect_val(SEx, "rst_mcycle", 32'h0);
    expect_val(SCl, "rst_mstatus", 32'h1800);
    drain();

    // Release: mcycle 0,1,2
    @(negedge clk);
    rst = 1'b0;
    expect_val(SEx, "mcycle0", 32'h0);
    expect_val(SCl, "mstatus_rd", 32'h1800);
    expect_val(SMstatus, "mstatus_o_rst", 32'h1800);
    expect_val(SGie, "gie_rst", 32'h0);
    expect_val(SMtvec, "mtvec_o_rst", 32'h0);
    expect_val(SMepc, "mepc_o_rst", 32'h0);
    drain();
    @(negedge clk);
    rd(32'hB00, 32'hF14);
    expect_val(SEx, "mcycle1", 32'h1);
    expect_val(SCl, "mhartid", 32'h0);
    drain();
    @(negedge clk);
    expect_val(SEx, "mcycle2", 32'h2);
    drain();

    // mstatus masking and MIE
    @(negedge clk);
    ex_wr(1, 32'h300, 32'hFFFF_FFFF);
    rd(32'h300, 32'h0);
    expect_val(SEx, "mstatus_bypass", 32'h1888);
    expect_val(SGie, "gie_before_edge", 32'h0);
    drain();
    @(negedge clk);
    ex_wr(0, 0, 0);
    expect_val(SEx, "mstatus_stored", 32'h1888);
    expect_val(SMstatus, "mstatus_o_set", 32'h1888);
    expect_val(SGie, "gie_set", 32'h1);
    drain();
    @(negedge clk);
    ex_wr(1, 32'h300, 32'h0);
    expect_val(SEx, "mstatus_clr_bypass", 32'h1800);
    expect_val(SGie, "gie_still_set", 32'h1);
    drain();
    @(negedge clk);
    ex_wr(0, 0, 0);
    expect_val(SGie, "gie_clr", 32'h0);
    expect_val(SMstatus, "mstatus_o_clr", 32'h1800);
    drain();

    // Dual-port writes: collision and independent
    @(negedge clk);
    ex_wr(1, 32'h341, 32'h100);
    cl_wr(1, 32'h341, 32'h204);
    rd(32'h341, 32'h0);
    expect_val(SEx, "mepc_collide_bypass", 32'h204);
    drain();
    @(negedge clk);
    ex_wr(1, 32'h340, 32'h55);
    cl_wr(1, 32'h341, 32'h20B);
    rd(32'h340, 32'h341);
    expect_val(SMepc, "mepc_o_collide", 32'h204);
    expect_val(SEx, "mscratch_bypass", 32'h55);
    expect_val(SCl, "mepc_mask_bypass", 32'h208);
    drain();
    @(negedge clk);
    ex_wr(0, 0, 0);
    cl_wr(0, 0, 0);
    expect_val(SEx, "mscratch_stored", 32'h55);
    expect_val(SCl, "mepc_stored", 32'h208);
    expect_val(SMepc, "mepc_o_both", 32'h208);
    drain();

    // Read bypass across ports, mtvec masking
    @(negedge clk);
    ex_wr(1, 32'h342, 32'hB);
    rd(32'h305, 32'h342);
    expect_val(SCl, "mcause_xport_bypass", 32'hB);
    expect_val(SEx, "mtvec_reset_rd", 32'h0);
    drain();
    @(negedge clk);
    ex_wr(0, 0, 0);
    cl_wr(1, 32'h305, 32'h8000_0003);
    expect_val(SEx, "mtvec_bypass", 32'h8000_0000);
    expect_val(SCl, "mcause_stored", 32'hB);
    drain();
    @(negedge clk);
    cl_wr(0, 0, 0);
    expect_val(SMtvec, "mtvec_o", 32'h8000_0000);
    drain();

    // Counter write and wrap
    @(negedge clk);
    ex_wr(1, 32'hB00, 32'hFFFF_FFFF);
    cl_wr(1, 32'hB80, 32'hFFFF_FFFF);
    rd(32'hB00, 32'hB80);
    expect_val(SEx, "mcycle_wr_bypass", 32'hFFFF_FFFF);
    expect_val(SCl, "mcycleh_wr_bypass", 32'hFFFF_FFFF);
    drain();
    @(negedge clk);
    ex_wr(0, 0, 0);
    cl_wr(0, 0, 0);
    expect_val(SEx, "mcycle_max", 32'hFFFF_FFFF);
    expect_val(SCl, "mcycleh_max", 32'hFFFF_FFFF);
    drain();
    @(negedge clk);
    expect_val(SEx, "mcycle_wrap", 32'h0);
    expect_val(SCl, "mcycleh_wrap", 32'h0);
    drain();

    // minstret write with retire asserted: no increment that cycle
    @(negedge clk);
    inst_retire_i = 1'b1;
    ex_wr(1, 32'hB02, 32'h1234);
    rd(32'hB02, 32'hB82);
    expect_val(SEx, "minstret_bypass", 32'h1234);
    expect_val(SCl, "minstreth_zero", 32'h0);
    drain();
    @(negedge clk);
    ex_wr(0, 0, 0);
    expect_val(SEx, "minstret_no_inc", 32'h1234);
    drain();
    @(negedge clk);
    inst_retire_i = 1'b0;
    expect_val(SEx, "minstret_inc", 32'h1235);
    drain();
    @(negedge clk);
    expect_val(SEx, "minstret_hold", 32'h1235);
    drain();

    // Unmapped, mhartid write, mie mask, high address bits ignored
    @(negedge clk);
    ex_wr(1, 32'h7C0, 32'hDEAD);
    cl_wr(1, 32'hF14, 32'h1);
    rd(32'h7C0, 32'hF14);
    expect_val(SEx, "unmapped_bypass", 32'h0);
    expect_val(SCl, "mhartid_wr_ignored", 32'h0);
    drain();
    @(negedge clk);
    ex_wr(1, 32'h304, 32'hFFFF_FFFF);
    cl_wr(0, 0, 0);
    rd(32'h7C0, 32'h304);
    expect_val(SEx, "unmapped_rd", 32'h0);
    expect_val(SCl, "mie_mask_bypass", 32'h888);
    drain();
    @(negedge clk);
    ex_wr(1, 32'hABC_D300, 32'h88);
    rd(32'hABC_D300, 32'h304);
    expect_val(SEx, "alias_mstatus_bypass", 32'h1888);
    expect_val(SCl, "mie_stored", 32'h888);
    drain();
    @(negedge clk);
    ex_wr(0, 0, 0);
    expect_val(SGie, "alias_gie", 32'h1);
    expect_val(SMstatus, "alias_mstatus_o", 32'h1888);
    drain();

    // Asynchronous reset mid-count
    @(negedge clk);
    inst_retire_i = 1'b1;
    rd(32'hB00, 32'hB02);
    #2;
    rst = 1'b1;
    expect_val(SEx, "async_rst_mcycle", 32'h0);
    expect_val(SCl, "async_rst_minstret", 32'h0);
    expect_val(SGie, "async_rst_gie", 32'h0);
    expect_val(SMtvec, "async_rst_mtvec", 32'h0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
